ring_router_nvc: RTL and testbench

- Next-generation bidirectional ring router for the cardinal ring NoC.
- Generalises the fixed 2-VC, polarity-driven router in three ways:
  - NUM_VC virtual channels with a rotating phase counter.
  - Ring size set by NUM_NODES, using a hop-count header.
  - Round-robin arbitration on every contended output.
- One instance per ring node. Neighbour links are cw/ccw; the PE/NIC port is pe. All instances reset together, so their phases stay in lockstep.

---
 rtl/ring_router_nvc.sv | 175 +++++++++++++++++
 tb/tb_ring_router_nvc.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/ring_router_nvc.sv
`default_nettype none
// ============================================================================
// Module  : ring_router_nvc
// Purpose : Bidirectional ring router node with NUM_VC phase-rotated virtual
//           channels, hop-count routing and round-robin output arbitration.
// Revision: 1.0
// ============================================================================
module ring_router_nvc #(
   parameter int PACKET_SIZE = 64,
   parameter int NUM_VC      = 2,
   parameter int NUM_NODES   = 8,
   parameter int VC_W        = $clog2(NUM_VC)
) (
   input  logic                   clk,
   input  logic                   reset,
   output logic [VC_W-1:0]        o_phase,
   input  logic                   i_cwsi,
   input  logic                   i_ccwsi,
   input  logic                   i_pesi,
   input  logic [PACKET_SIZE-1:0] i_cwdi,
   input  logic [PACKET_SIZE-1:0] i_ccwdi,
   input  logic [PACKET_SIZE-1:0] i_pedi,
   output logic                   o_cwro,
   output logic                   o_ccwro,
   output logic                   o_pero,
   output logic                   o_cwso,
   output logic                   o_ccwso,
   output logic                   o_peso,
   output logic [PACKET_SIZE-1:0] o_cwdo,
   output logic [PACKET_SIZE-1:0] o_ccwdo,
   output logic [PACKET_SIZE-1:0] o_pedo,
   input  logic                   i_cwri,
   input  logic                   i_ccwri,
   input  logic                   i_peri
);
   localparam int c_HOP_W   = $clog2(NUM_NODES);
   localparam int c_HOP_LSB = PACKET_SIZE - 1 - VC_W - c_HOP_W;
   localparam logic [PACKET_SIZE-1:0] c_HOP_ONE = PACKET_SIZE'(1) << c_HOP_LSB;

   // Port index 0 = cw, 1 = ccw, 2 = pe
   logic [VC_W-1:0]        r_phase;
   logic [NUM_VC-1:0]      r_in_vld   [3];
   logic [NUM_VC-1:0]      r_out_vld  [3];
   logic [PACKET_SIZE-1:0] r_in_data  [3][NUM_VC];
   logic [PACKET_SIZE-1:0] r_out_data [3][NUM_VC];
   logic [1:0]             r_ptr_pe   [NUM_VC];
   logic [NUM_VC-1:0]      r_ptr_cw;
   logic [NUM_VC-1:0]      r_ptr_ccw;

   logic [2:0]             w_si;
   logic [2:0]             w_ri;
   logic [2:0]             w_so;
   logic [2:0]             w_ro;
   logic [PACKET_SIZE-1:0] w_di       [3];
   logic [2:0]             w_req_pe   [NUM_VC];
   logic [1:0]             w_req_cw   [NUM_VC];
   logic [1:0]             w_req_ccw  [NUM_VC];
   logic [2:0]             w_gnt_pe   [NUM_VC];
   logic [1:0]             w_gnt_cw   [NUM_VC];
   logic [1:0]             w_gnt_ccw  [NUM_VC];

   assign w_si = {i_pesi, i_ccwsi, i_cwsi};
   assign w_ri = {i_peri, i_ccwri, i_cwri};
   assign w_di[0] = i_cwdi;
   assign w_di[1] = i_ccwdi;
   assign w_di[2] = i_pedi;

   function automatic logic [2:0] f_rr3(input logic [2:0] req, input logic [1:0] ptr);
      logic [2:0] gnt;
      case (ptr)
         2'd1:    gnt = req[1] ? 3'b010 : req[2] ? 3'b100 : req[0] ? 3'b001 : 3'b000;
         2'd2:    gnt = req[2] ? 3'b100 : req[0] ? 3'b001 : req[1] ? 3'b010 : 3'b000;
         default: gnt = req[0] ? 3'b001 : req[1] ? 3'b010 : req[2] ? 3'b100 : 3'b000;
      endcase
      return gnt;
   endfunction

   function automatic logic [1:0] f_rr2(input logic [1:0] req, input logic ptr);
      logic [1:0] gnt;
      if (&req) gnt = ptr ? 2'b10 : 2'b01;
      else      gnt = req;
      return gnt;
   endfunction

   always_comb begin
      for (int x = 0; x < 3; x++) begin
         w_so[x] = r_out_vld[x][r_phase] & w_ri[x];
         w_ro[x] = ~r_in_vld[x][r_phase];
      end
      // Internal stage only touches VCs that the link stage is not using this cycle
      for (int v = 0; v < NUM_VC; v++) begin
         w_req_pe[v][0]  = (VC_W'(v) != r_phase) & r_in_vld[0][v] & ~r_out_vld[2][v]
                         & (r_in_data[0][v][c_HOP_LSB +: c_HOP_W] == '0);
         w_req_pe[v][1]  = (VC_W'(v) != r_phase) & r_in_vld[1][v] & ~r_out_vld[2][v]
                         & (r_in_data[1][v][c_HOP_LSB +: c_HOP_W] == '0);
         w_req_pe[v][2]  = (VC_W'(v) != r_phase) & r_in_vld[2][v] & ~r_out_vld[2][v]
                         & (r_in_data[2][v][c_HOP_LSB +: c_HOP_W] == '0);
         w_req_cw[v][0]  = (VC_W'(v) != r_phase) & r_in_vld[0][v] & ~r_out_vld[0][v]
                         & (r_in_data[0][v][c_HOP_LSB +: c_HOP_W] != '0);
         w_req_cw[v][1]  = (VC_W'(v) != r_phase) & r_in_vld[2][v] & ~r_out_vld[0][v]
                         & (r_in_data[2][v][c_HOP_LSB +: c_HOP_W] != '0)
                         & ~r_in_data[2][v][PACKET_SIZE-1];
         w_req_ccw[v][0] = (VC_W'(v) != r_phase) & r_in_vld[1][v] & ~r_out_vld[1][v]
                         & (r_in_data[1][v][c_HOP_LSB +: c_HOP_W] != '0);
         w_req_ccw[v][1] = (VC_W'(v) != r_phase) & r_in_vld[2][v] & ~r_out_vld[1][v]
                         & (r_in_data[2][v][c_HOP_LSB +: c_HOP_W] != '0)
                         & r_in_data[2][v][PACKET_SIZE-1];
         w_gnt_pe[v]  = f_rr3(w_req_pe[v], r_ptr_pe[v]);
         w_gnt_cw[v]  = f_rr2(w_req_cw[v], r_ptr_cw[v]);
         w_gnt_ccw[v] = f_rr2(w_req_ccw[v], r_ptr_ccw[v]);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_phase   <= '0;
         r_ptr_cw  <= '0;
         r_ptr_ccw <= '0;
         for (int x = 0; x < 3; x++) begin
            r_in_vld[x]  <= '0;
            r_out_vld[x] <= '0;
            for (int v = 0; v < NUM_VC; v++) begin
               r_in_data[x][v]  <= '0;
               r_out_data[x][v] <= '0;
            end
         end
         for (int v = 0; v < NUM_VC; v++) r_ptr_pe[v] <= '0;
      end else begin
         r_phase <= (r_phase == VC_W'(NUM_VC - 1)) ? '0 : r_phase + 1'b1;
         for (int x = 0; x < 3; x++) begin
            if (w_so[x]) r_out_vld[x][r_phase] <= 1'b0;
            if (w_si[x] && w_ro[x]) begin
               r_in_vld[x][r_phase]  <= 1'b1;
               r_in_data[x][r_phase] <= w_di[x];
            end
         end
         for (int v = 0; v < NUM_VC; v++) begin
            if (w_gnt_pe[v][0] | w_gnt_cw[v][0])                  r_in_vld[0][v] <= 1'b0;
            if (w_gnt_pe[v][1] | w_gnt_ccw[v][0])                 r_in_vld[1][v] <= 1'b0;
            if (w_gnt_pe[v][2] | w_gnt_cw[v][1] | w_gnt_ccw[v][1]) r_in_vld[2][v] <= 1'b0;
            if (|w_gnt_pe[v]) begin
               r_out_vld[2][v]  <= 1'b1;
               r_out_data[2][v] <= w_gnt_pe[v][0] ? r_in_data[0][v] :
                                   w_gnt_pe[v][1] ? r_in_data[1][v] : r_in_data[2][v];
            end
            if (|w_gnt_cw[v]) begin
               r_out_vld[0][v]  <= 1'b1;
               r_out_data[0][v] <= w_gnt_cw[v][0] ? r_in_data[0][v] - c_HOP_ONE : r_in_data[2][v];
            end
            if (|w_gnt_ccw[v]) begin
               r_out_vld[1][v]  <= 1'b1;
               r_out_data[1][v] <= w_gnt_ccw[v][0] ? r_in_data[1][v] - c_HOP_ONE : r_in_data[2][v];
            end
            // Pointers move only on contention, to the contender after the winner
            if ($countones(w_req_pe[v]) > 1)
               r_ptr_pe[v] <= w_gnt_pe[v][0] ? 2'd1 : w_gnt_pe[v][1] ? 2'd2 : 2'd0;
            if (&w_req_cw[v])  r_ptr_cw[v]  <= w_gnt_cw[v][0];
            if (&w_req_ccw[v]) r_ptr_ccw[v] <= w_gnt_ccw[v][0];
         end
      end
   end

   assign o_phase = r_phase;
   assign o_cwro  = w_ro[0];
   assign o_ccwro = w_ro[1];
   assign o_pero  = w_ro[2];
   assign o_cwso  = w_so[0];
   assign o_ccwso = w_so[1];
   assign o_peso  = w_so[2];
   assign o_cwdo  = w_so[0] ? r_out_data[0][r_phase] : '0;
   assign o_ccwdo = w_so[1] ? r_out_data[1][r_phase] : '0;
   assign o_pedo  = w_so[2] ? r_out_data[2][r_phase] : '0;

endmodule
`default_nettype wire

// File: tb/tb_ring_router_nvc.sv
`default_nettype none
// ============================================================================
// Module  : tb_ring_router_nvc
// Purpose : Directed self-checking bench for ring_router_nvc (2-VC and 4-VC).
// Revision: 1.0
// ============================================================================
module tb_ring_router_nvc;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   // 2-VC, 64-bit instance: [63] dir, [62] vc, [61:59] hop, [58:0] payload
   logic [0:0]  phase;
   logic        cwsi, ccwsi, pesi, cwro, ccwro, pero, cwso, ccwso, peso, cwri, ccwri, peri;
   logic [63:0] cwdi, ccwdi, pedi, cwdo, ccwdo, pedo;
   // 4-VC, 32-bit instance: [31] dir, [30:29] vc, [28:26] hop, [25:0] payload
   logic [1:0]  phase4;
   logic        cwsi4, ccwsi4, pesi4, cwro4, ccwro4, pero4, cwso4, ccwso4, peso4;
   logic        cwri4, ccwri4, peri4;
   logic [31:0] cwdi4, ccwdi4, pedi4, cwdo4, ccwdo4, pedo4;

   int checks = 0;
   int errors = 0;

   ring_router_nvc #(.PACKET_SIZE(64), .NUM_VC(2), .NUM_NODES(8)) u_dut (
      .clk(clk), .reset(reset), .o_phase(phase),
      .i_cwsi(cwsi), .i_ccwsi(ccwsi), .i_pesi(pesi),
      .i_cwdi(cwdi), .i_ccwdi(ccwdi), .i_pedi(pedi),
      .o_cwro(cwro), .o_ccwro(ccwro), .o_pero(pero),
      .o_cwso(cwso), .o_ccwso(ccwso), .o_peso(peso),
      .o_cwdo(cwdo), .o_ccwdo(ccwdo), .o_pedo(pedo),
      .i_cwri(cwri), .i_ccwri(ccwri), .i_peri(peri));

   ring_router_nvc #(.PACKET_SIZE(32), .NUM_VC(4), .NUM_NODES(8)) u_dut4 (
      .clk(clk), .reset(reset), .o_phase(phase4),
      .i_cwsi(cwsi4), .i_ccwsi(ccwsi4), .i_pesi(pesi4),
      .i_cwdi(cwdi4), .i_ccwdi(ccwdi4), .i_pedi(pedi4),
      .o_cwro(cwro4), .o_ccwro(ccwro4), .o_pero(pero4),
      .o_cwso(cwso4), .o_ccwso(ccwso4), .o_peso(peso4),
      .o_cwdo(cwdo4), .o_ccwdo(ccwdo4), .o_pedo(pedo4),
      .i_cwri(cwri4), .i_ccwri(ccwri4), .i_peri(peri4));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ph(input logic [0:0] p);
      for (int i = 0; i < 4 && phase != p; i++) tick;
      chk("wait_phase", 64'(phase), 64'(p));
   endtask

   function automatic logic [63:0] mk(input logic d, input logic vc, input logic [2:0] hop,
                                      input logic [58:0] pl);
      return {d, vc, hop, pl};
   endfunction

   function automatic logic [31:0] mk4(input logic d, input logic [1:0] vc, input logic [2:0] hop,
                                       input logic [25:0] pl);
      return {d, vc, hop, pl};
   endfunction

   initial begin
      logic [63:0] p1, p3, pa, pb, pa2, pb2, p5, pq, pr;
      logic [31:0] v4;
      p1  = mk(1'b0, 1'b1, 3'd2, 59'hABCD);
      p3  = mk(1'b0, 1'b1, 3'd0, 59'h1234_5678);
      pa  = mk(1'b0, 1'b0, 3'd0, 59'h0A);
      pb  = mk(1'b1, 1'b0, 3'd0, 59'h0B);
      pa2 = mk(1'b0, 1'b0, 3'd0, 59'h1A);
      pb2 = mk(1'b1, 1'b0, 3'd0, 59'h1B);
      p5  = mk(1'b0, 1'b1, 3'd3, 59'h77);
      pq  = mk(1'b0, 1'b1, 3'd2, 59'h88);
      pr  = mk(1'b0, 1'b1, 3'd0, 59'h99);
      v4  = mk4(1'b0, 2'd3, 3'd1, 26'h55);

      reset = 1'b0;
      {cwsi, ccwsi, pesi, cwsi4, ccwsi4, pesi4} = '0;
      {cwdi, ccwdi, pedi} = '0;
      {cwdi4, ccwdi4, pedi4} = '0;
      {cwri, ccwri, peri, cwri4, ccwri4, peri4} = '1;

      #12;
      chk("rst_phase", 64'(phase), 64'd0);
      chk("rst_so", {61'd0, cwso, ccwso, peso}, 64'd0);
      chk("rst_ro", {61'd0, cwro, ccwro, pero}, 64'd7);
      chk("rst_cwdo", cwdo, 64'd0);
      reset = 1'b1;
      #1;
      for (int i = 0; i < 5; i++) begin
         chk("phase2", 64'(phase), 64'(i % 2));
         chk("phase4", 64'(phase4), 64'(i % 4));
         tick;
      end

      // PE injection toward cw, hop unchanged
      wait_ph(1'b1);
      pesi = 1'b1; pedi = p1;
      #1 chk("pe_ro", 64'(pero), 64'd1);
      tick; pesi = 1'b0; pedi = '0;
      #1 chk("inj_cwso_ph0", 64'(cwso), 64'd0);
      tick;
      #1 chk("inj_cwso", 64'(cwso), 64'd1);
      chk("inj_cwdo", cwdo, p1);
      chk("inj_pero", 64'(pero), 64'd1);
      tick;
      #1 chk("inj_cwso_clr", 64'(cwso), 64'd0);

      // Forwarding decrements hop
      wait_ph(1'b1);
      cwsi = 1'b1; cwdi = p1;
      #1 chk("fwd_cwro", 64'(cwro), 64'd1);
      tick; cwsi = 1'b0;
      tick;
      #1 chk("fwd_cwso", 64'(cwso), 64'd1);
      chk("fwd_cwdo", cwdo, mk(1'b0, 1'b1, 3'd1, 59'hABCD));

      // hop 0 ejects to PE
      tick; wait_ph(1'b1);
      cwsi = 1'b1; cwdi = p3;
      tick; cwsi = 1'b0;
      tick;
      #1 chk("ej_peso", 64'(peso), 64'd1);
      chk("ej_pedo", pedo, p3);
      chk("ej_cwso", 64'(cwso), 64'd0);

      // Arbitration on PE output VC0
      tick; wait_ph(1'b0);
      cwsi = 1'b1; cwdi = pa; ccwsi = 1'b1; ccwdi = pb;
      #1 chk("arb_ro", {62'd0, cwro, ccwro}, 64'd3);
      tick; cwsi = 1'b0; ccwsi = 1'b0;
      #1 chk("arb1_peso_ph1", 64'(peso), 64'd0);
      tick;
      #1 chk("arb1_first", pedo, pa);
      chk("arb1_ccwro", 64'(ccwro), 64'd0);
      chk("arb1_cwro", 64'(cwro), 64'd1);
      tick;
      #1 chk("arb1_gap", 64'(peso), 64'd0);
      tick;
      #1 chk("arb1_second", pedo, pb);
      chk("arb1_peso", 64'(peso), 64'd1);
      cwsi = 1'b1; cwdi = pa2; ccwsi = 1'b1; ccwdi = pb2;
      tick; cwsi = 1'b0; ccwsi = 1'b0;
      tick;
      #1 chk("arb2_first", pedo, pb2);
      tick; tick;
      #1 chk("arb2_second", pedo, pa2);

      // Backpressure on cw output
      tick; wait_ph(1'b1);
      cwri = 1'b0; pesi = 1'b1; pedi = p5;
      tick; pesi = 1'b0;
      tick;
      cwsi = 1'b1; cwdi = pq;
      #1 chk("bp_cwro_pre", 64'(cwro), 64'd1);
      tick; cwsi = 1'b0;
      for (int i = 0; i < 10; i++) begin
         #1 chk("bp_cwso", 64'(cwso), 64'd0);
         chk("bp_cwdo", cwdo, 64'd0);
         if (phase == 1'b1) chk("bp_cwro", 64'(cwro), 64'd0);
         tick;
      end
      wait_ph(1'b1);
      cwsi = 1'b1; cwdi = pr;
      #1 chk("viol_cwro", 64'(cwro), 64'd0);
      tick; cwsi = 1'b0;
      tick; cwri = 1'b1;
      #1 chk("bp_rel_cwso", 64'(cwso), 64'd1);
      chk("bp_rel_cwdo", cwdo, p5);
      tick; tick;
      #1 chk("bp_q_cwso", 64'(cwso), 64'd1);
      chk("bp_q_cwdo", cwdo, mk(1'b0, 1'b1, 3'd1, 59'h88));
      chk("viol_peso", 64'(peso), 64'd0);
      tick; tick;
      #1 chk("bp_nodup_cwso", 64'(cwso), 64'd0);
      chk("bp_nodup_peso", 64'(peso), 64'd0);

      // Asynchronous reset with buffers full
      cwri = 1'b0; cwsi = 1'b1; cwdi = pq; pesi = 1'b1; pedi = p5;
      #1 chk("ar_cwro", 64'(cwro), 64'd1);
      tick; cwsi = 1'b0; pesi = 1'b0;
      tick;
      #1 chk("ar_pero_full", 64'(pero), 64'd0);
      chk("ar_cwso_held", 64'(cwso), 64'd0);
      cwri = 1'b1;
      #1 chk("ar_cwso_pre", 64'(cwso), 64'd1);
      chk("ar_cwdo_pre", cwdo, mk(1'b0, 1'b1, 3'd1, 59'h88));
      reset = 1'b0;
      #1 chk("ar_phase", 64'(phase), 64'd0);
      chk("ar_cwso", 64'(cwso), 64'd0);
      chk("ar_cwdo", cwdo, 64'd0);
      chk("ar_ro", {62'd0, cwro, pero}, 64'd3);
      #1 reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick;
         #1 chk("ar_flush", {62'd0, cwso, peso}, 64'd0);
      end

      // 4-VC phase gating of a vc=3 packet
      for (int i = 0; i < 8 && phase4 != 2'd3; i++) tick;
      chk("g4_wait", 64'(phase4), 64'd3);
      pesi4 = 1'b1; pedi4 = v4;
      #1 chk("g4_pero", 64'(pero4), 64'd1);
      tick; pesi4 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1 chk("g4_phase", 64'(phase4), 64'(i));
         chk("g4_cwso_idle", 64'(cwso4), 64'd0);
         chk("g4_cwdo_idle", 64'(cwdo4), 64'd0);
         tick;
      end
      #1 chk("g4_cwso", 64'(cwso4), 64'd1);
      chk("g4_cwdo", 64'(cwdo4), 64'(v4));
      tick;
      #1 chk("g4_cwso_clr", 64'(cwso4), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
